param_priority_arbiter: RTL
===========================

Name: param_priority_arbiter

Overview:
Parametrised, registered successor to the 8-bit combinational priority encoder. It captures N request lines into a sticky pending register and issues one grant at a time as both an index and a one-hot vector. Each grant is held under a valid/ready handshake until the consumer accepts it. Priority is either fixed (highest index wins, same ordering as the existing encoder) or round-robin. It sits between interrupt/event sources and a single shared service unit.

Parameters:
N, 8, number of requesters; legal range 2..64.
MODE, 0, arbitration mode; 0 = fixed priority (index N-1 highest), 1 = round-robin.
W, $clog2(N), width of the grant index; derived, not overridden.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  N  request vector; bit i high = requester i wants service.
gnt_ready  in  1  consumer accepts the current grant this cycle.
gnt_valid  out  1  a grant is presented; registered.
gnt_idx  out  W  index of the granted requester; registered.
gnt_onehot  out  N  one-hot form of gnt_idx; all zero when gnt_valid=0; registered.
pend_vec  out  N  current pending register contents, for status and debug.

Behaviour:
- Reset (async, immediate, independent of clk): pending=0, gnt_valid=0, gnt_idx=0, gnt_onehot=0, rr_ptr=N-1. A reset asserted mid-grant drops the grant and discards all pending requests.
- accept = gnt_valid & gnt_ready. accept_mask = gnt_onehot if accept, else 0.
- Pending update each edge: pending_next = (pending & ~accept_mask) | req. Requests are sticky and need only be high for 1 cycle.
- A request on the index being accepted in the same cycle re-arms that bit; it is not lost.
- There are two states:
  - IDLE (gnt_valid=0): if pending_next != 0, select a winner from pending_next and go to GRANT at this edge. Otherwise stay in IDLE.
  - GRANT (gnt_valid=1): gnt_idx and gnt_onehot are frozen while gnt_ready=0. There is no preemption by higher-priority requests.
    - On accept with the remaining pending_next != 0: select the next winner at the same edge and stay in GRANT. There is no bubble between grants.
    - On accept with pending_next = 0: go to IDLE.
- Latency: req high before edge k gives gnt_valid=1 after edge k when idle. Sustained throughput is 1 grant per cycle with gnt_ready tied high.
- Fixed mode (MODE=0): winner is the highest set index of pending_next. rr_ptr is unused.
- Round-robin mode (MODE=1):
  - Search descends from rr_ptr, wrapping modulo N, i.e. order rr_ptr, rr_ptr-1, ..., 0, N-1, ...
  - On each accept, rr_ptr <= (accepted_idx - 1) mod N, so the accepted index becomes lowest priority.
  - rr_ptr changes only on accept, never on issue.
- With all of pending_next = 0 the selector output is ignored. gnt_idx holds its last value while gnt_valid=0; gnt_onehot goes to 0.
- gnt_onehot is always exactly equal to (1 << gnt_idx) when gnt_valid=1.
- All outputs are registered; there are no combinational paths from req or gnt_ready to outputs.

Decomposition:
- The shared package holds:
  - MODE_FIXED=0 and MODE_RR=1 localparams;
  - a constant clog2 function;
  - an onehot-from-index function.
- Sub-module prio_find, purely combinational: given vec[N] and start index, returns found and idx of the first set bit searching downward from start with wrap. Fixed mode instantiates it with start=N-1.

Test Plan:
1. MODE=0, N=8, single-cycle req=8'b0010_0110, gnt_ready=1 → gnt_idx 5, 2, 1 on three consecutive cycles, then gnt_valid=0 and pend_vec=0.
2. MODE=0, req=8'h01 pulse, gnt_ready=0 for 4 cycles, req=8'h80 pulse during the hold → grant stays idx 0 with onehot 8'h01. After gnt_ready=1, idx 7 is granted the next cycle with no idle gap.
3. req=8'hFF held, gnt_ready=1 → MODE=1 gives idx 7,6,5,4,3,2,1,0,7. MODE=0 gives idx 7 every cycle.
4. MODE=1, accept idx 0, then pending=8'h81 → next grant idx 7 (wrap). After accepting 7, a re-request of 8'h81 grants idx 0.
5. Accept idx 3 while req[3]=1 in the same cycle → bit 3 remains set in pend_vec and is granted again later.
6. rst asserted between edges while gnt_valid=1, pending=8'h3C → gnt_valid, gnt_onehot and pend_vec go to 0 without a clock edge. After release, the first request is arbitrated as from reset, with rr_ptr=N-1.

Source files
------------

// File: rtl/param_priority_arbiter_pkg.sv
// Shared constants and helpers for the registered priority/round-robin arbiter.
package param_priority_arbiter_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Callers narrow the result to their own requester count.
    function automatic logic [63:0] onehot_from_idx(input logic [5:0] idx);
        return 64'd1 << idx;
    endfunction

endpackage

// File: rtl/param_priority_arbiter_if.sv
// Request/grant bundle between event sources, the arbiter and the service unit.
interface param_priority_arbiter_if
    import param_priority_arbiter_pkg::*;
#(
    parameter int N = 8
);
    localparam int W = clog2(N);

    logic [N-1:0] req;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;
    logic [N-1:0] pend_vec;

    modport master (
        output req, gnt_ready,
        input  gnt_valid, gnt_idx, gnt_onehot, pend_vec
    );

    modport slave (
        input  req, gnt_ready,
        output gnt_valid, gnt_idx, gnt_onehot, pend_vec
    );

endinterface

// File: rtl/param_priority_arbiter_prio_find.sv
// Finds the first set bit of vec, searching downward from start and wrapping at 0.
module prio_find
    import param_priority_arbiter_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin : search
        int pos;
        // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned (no latch).
        found = |vec;
        idx   = '0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) - k;
            if (pos < 0) pos += N;
            if (vec[pos]) idx = pos[W-1:0];
        end
    end

endmodule

// File: rtl/param_priority_arbiter.sv
// Sticky-pending arbiter issuing one registered grant at a time under valid/ready.
module param_priority_arbiter
    import param_priority_arbiter_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED
) (
    input  logic                    clk,
    input  logic                    rst,
    param_priority_arbiter_if.slave bus
);

    localparam int W = clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    state_t       state;
    logic [N-1:0] pending;
    logic [N-1:0] gnt_onehot;
    logic [W-1:0] gnt_idx;
    logic [W-1:0] rr_ptr;

    logic         gnt_valid;
    logic         accept;
    logic [N-1:0] accept_mask;
    logic [N-1:0] pending_next;
    logic [W-1:0] rr_next;
    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] win_idx;
    logic [N-1:0] win_oh;

    assign gnt_valid    = (state == ST_GRANT);
    assign accept       = gnt_valid & bus.gnt_ready;
    assign accept_mask  = accept ? gnt_onehot : '0;
    assign pending_next = (pending & ~accept_mask) | bus.req;

    // The search for the next winner already uses the pointer this accept produces.
    assign rr_next = !accept           ? rr_ptr :
                     (gnt_idx == '0)   ? LAST   : gnt_idx - 1'b1;
    assign start   = (MODE == MODE_RR) ? rr_next : LAST;

    prio_find #(.N(N), .W(W)) u_find (
        .vec   (pending_next),
        .start (start),
        .found (found),
        .idx   (win_idx)
    );

    assign win_oh = N'(onehot_from_idx(6'(win_idx)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pending    <= '0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            rr_ptr     <= LAST;
        end else begin
            pending <= pending_next;
            rr_ptr  <= rr_next;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state      <= ST_GRANT;
                        gnt_idx    <= win_idx;
                        gnt_onehot <= win_oh;
                    end
                end
                ST_GRANT: begin
                    if (accept) begin
                        if (found) begin
                            gnt_idx    <= win_idx;
                            gnt_onehot <= win_oh;
                        end else begin
                            state      <= ST_IDLE;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt_valid  = gnt_valid;
    assign bus.gnt_idx    = gnt_idx;
    assign bus.gnt_onehot = gnt_onehot;
    assign bus.pend_vec   = pending;

endmodule
